mul_serial_ctrl: RTL and testbench
==================================

Name: mul_serial_ctrl

Overview:
- Sequencer for the bit-serial multiplier inner unit in the 8-bit binaryserial datapath.
- Accepts one signed operand pair over a valid/ready handshake, then steps the inner unit's bit index from 0 to WIDTH-1.
- Accumulates the shifted partial products it returns, with a negative MSB weight, and presents the full two's-complement product over a valid/ready output handshake.
- One operation is in flight at a time; a new operand pair can be accepted in the same cycle the previous result is consumed.

Parameters:
- WIDTH, 8, operand width in bits (signed two's complement).
- DEPTH, 3, index width; must equal clog2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operand pair valid.
- i_ready  output  1  controller can accept an operand pair.
- i_a  input  WIDTH  signed multiplier; its bits are scanned serially.
- i_b  input  WIDTH  signed multiplicand.
- o_valid  output  1  result valid.
- o_ready  input  1  downstream accepts the result.
- o_data  output  2*WIDTH  signed product a*b.
- o_busy  output  1  high whenever the state is not IDLE.
- mul_en  output  1  enable to the inner unit (loads its index register).
- mul_clr  output  1  synchronous clear of the inner unit's index register.
- mul_idx  output  DEPTH  bit index issued to the inner unit.
- mul_data0  output  WIDTH  latched i_a, driven to the inner unit.
- mul_data1  output  WIDTH  latched i_b, driven to the inner unit.
- mul_pp  input  2*WIDTH  partial product from the inner unit: sign-extended b when bit[registered idx] of a is 1, else 0. It reflects the index registered on the previous enabled edge.

Behaviour:
- Reset (asynchronous): state=IDLE, cnt=0, acc=0, a_r=0, b_r=0.
- Reset output values: i_ready=1, o_valid=0, o_data=0, o_busy=0, mul_en=0, mul_clr=0, mul_idx=0.
- States: IDLE, RUN, DONE. The state is never undefined; any illegal encoding returns to IDLE.
- Accept: occurs when i_valid & i_ready.
  - i_ready = (state==IDLE) | (state==DONE & o_ready). This is combinational from o_ready.
- On accept (cycle 0):
  - a_r<=i_a, b_r<=i_b, acc<=0, cnt<=0; next state RUN.
  - Same cycle: mul_en=1, mul_idx=0.
- RUN: cnt is the index currently registered in the inner unit. Each cycle:
  - term = mul_pp shifted left by cnt, kept in 2*WIDTH bits.
  - acc <= acc + term when cnt<WIDTH-1; acc <= acc - term when cnt==WIDTH-1 (MSB weight is -2^(WIDTH-1)).
  - If cnt<WIDTH-1: mul_en=1, mul_idx=cnt+1, cnt<=cnt+1.
  - If cnt==WIDTH-1: mul_en=0, mul_clr=1, next state DONE.
- DONE:
  - o_valid=1, o_data=acc; both are held stable while o_ready=0.
  - On o_ready: o_valid drops the next cycle. Next state is RUN if a new accept happens in the same cycle (a_r/b_r/acc/cnt reload as on a normal accept), else IDLE.
- Latency: accept at cycle 0 -> o_valid at cycle WIDTH+1. Throughput is one result per WIDTH+1 cycles when back-to-back.
- mul_data0/mul_data1 are always a_r/b_r; they are never driven from the live inputs.
- Outside the cases above: mul_en=0, mul_clr=0, mul_idx=0.
- Width rules: all arithmetic is 2*WIDTH-bit signed, with no overflow.
  - Extremes: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), and -2^(W-1)*(2^(W-1)-1). Both are exact.
- i_valid while busy (RUN, or DONE without o_ready) is ignored and not accepted. The upstream must hold its operands.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted, no result is emitted, and all reset values apply immediately.
- Zero operand: the full WIDTH+1 cycles still run; there is no early termination.

Test Plan:
- 3 × 5, o_ready=1 -> o_valid high exactly at cycle 9 after accept, o_data=15, then returns to IDLE.
- -128 × -128 -> o_data=16384. Also -128 × 127 -> o_data=-16256.
- -1 × 127 -> o_data=-127. Also 0 × -7 -> 0 after the full 9 cycles.
- o_ready held low 5 cycles in DONE with i_valid high:
  - o_valid/o_data stay stable and i_ready=0 throughout.
  - Raising o_ready accepts the new pair in that same cycle, and the next result arrives 9 cycles later.
- Back-to-back stream of 4 pairs with o_ready=1 -> results every 9 cycles, in order, all correct. mul_idx sequence per op is 0..7, with mul_clr pulsed once per op.
- Assert rst_n low at RUN cnt=4 -> outputs at reset values. The next op 2 × 3 -> 6, with no residue from the aborted op.

Source files
------------

// File: rtl/mul_serial_ctrl_if.sv
// Operand and result handshakes of the serial multiplier sequencer.
// The slave modport is the sequencer; the master modport is its producer/consumer.
interface mul_serial_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic               i_valid;
   logic               i_ready;
   logic [WIDTH-1:0]   i_a;
   logic [WIDTH-1:0]   i_b;
   logic               o_valid;
   logic               o_ready;
   logic [2*WIDTH-1:0] o_data;

   modport slave (
      input  i_valid, i_a, i_b, o_ready,
      output i_ready, o_valid, o_data
   );

   modport master (
      output i_valid, i_a, i_b, o_ready,
      input  i_ready, o_valid, o_data
   );
endinterface

// File: rtl/mul_serial_ctrl.sv
// Sequencer for the bit-serial multiplier inner unit: scans the bits of a, accumulates the
// shifted partial products (MSB weighted negative) and returns the signed product.
module mul_serial_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   mul_serial_ctrl_if.slave   bus,
   output logic               o_busy,
   output logic               mul_en,
   output logic               mul_clr,
   output logic [DEPTH-1:0]   mul_idx,
   output logic [WIDTH-1:0]   mul_data0,
   output logic [WIDTH-1:0]   mul_data1,
   input  logic [2*WIDTH-1:0] mul_pp
);

   localparam logic [DEPTH-1:0] LastIdx = DEPTH'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [DEPTH-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   term;

   assign term      = mul_pp << cnt_q;
   assign mul_data0 = a_q;
   assign mul_data1 = b_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      a_d         = a_q;
      b_d         = b_q;
      mul_en      = 1'b0;
      mul_clr     = 1'b0;
      mul_idx     = '0;
      bus.i_ready = 1'b0;
      bus.o_valid = 1'b0;
      bus.o_data  = '0;
      o_busy      = 1'b1;

      unique case (state_q)
         StIdle: begin
            o_busy      = 1'b0;
            bus.i_ready = 1'b1;
         end
         StRun: begin
            // cnt_q is the index the inner unit registered on the previous edge
            if (cnt_q == LastIdx) begin
               acc_d   = acc_q - term;
               mul_clr = 1'b1;
               state_d = StDone;
            end else begin
               acc_d   = acc_q + term;
               mul_en  = 1'b1;
               mul_idx = cnt_q + 1'b1;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         StDone: begin
            bus.o_valid = 1'b1;
            bus.o_data  = acc_q;
            bus.i_ready = bus.o_ready;
            if (bus.o_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Accept overrides the per-state update so a result hand-off can reload in one cycle
      if (bus.i_valid && bus.i_ready) begin
         a_d     = bus.i_a;
         b_d     = bus.i_b;
         acc_d   = '0;
         cnt_d   = '0;
         state_d = StRun;
         mul_en  = 1'b1;
         mul_idx = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

endmodule

// File: tb/tb_mul_serial_ctrl.sv
// Scoreboard bench for mul_serial_ctrl: a small inner-unit model supplies partial products,
// expected products come from plain signed multiplication of the issued operands.
module tb_mul_serial_ctrl;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 3;

   typedef struct {
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic [2*WIDTH-1:0] prod;
      int                 cyc;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               o_busy, mul_en, mul_clr;
   logic [DEPTH-1:0]   mul_idx;
   logic [WIDTH-1:0]   mul_data0, mul_data1;
   logic [2*WIDTH-1:0] mul_pp;
   logic [DEPTH-1:0]   pu_idx;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   n_results = 0;
   int   n_clr = 0;
   int   idx_exp = 0;
   bit   rand_ready = 1'b0;
   exp_t sb[$];

   logic               prev_v, prev_r;
   logic [2*WIDTH-1:0] prev_d;

   mul_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

   mul_serial_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .o_busy    (o_busy),
      .mul_en    (mul_en),
      .mul_clr   (mul_clr),
      .mul_idx   (mul_idx),
      .mul_data0 (mul_data0),
      .mul_data1 (mul_data1),
      .mul_pp    (mul_pp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Inner unit: index register loaded on enable, cleared by mul_clr
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pu_idx <= '0;
      else if (mul_clr) pu_idx <= '0;
      else if (mul_en) pu_idx <= mul_idx;
   end
   assign mul_pp = mul_data0[pu_idx] ? {{WIDTH{mul_data1[WIDTH-1]}}, mul_data1} : '0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*WIDTH-1:0] prod_of(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[2*WIDTH-1:0];
   endfunction

   // Result monitor: stability, latency and product checks
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v <= 1'b0;
         prev_r <= 1'b0;
         prev_d <= '0;
      end else begin
         if (prev_v && !prev_r) begin
            chk("hold_valid", longint'(bus.o_valid), 1);
            chk("hold_data", longint'(bus.o_data), longint'(prev_d));
         end
         if (prev_v && prev_r) chk("valid_drop", longint'(bus.o_valid), 0);
         if (bus.o_valid) begin
            if (!bus.o_ready) chk("iready_stall", longint'(bus.i_ready), 0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %0d expected none", $signed(bus.o_data));
            end else begin
               if (!prev_v) chk("latency", cyc - sb[0].cyc, WIDTH + 1);
               chk("mul_data0", longint'(mul_data0), longint'(sb[0].a));
               chk("mul_data1", longint'(mul_data1), longint'(sb[0].b));
               if (bus.o_ready) begin
                  chk("product", longint'($signed(bus.o_data)), longint'($signed(sb[0].prod)));
                  void'(sb.pop_front());
                  n_results++;
               end
            end
         end
         prev_v <= bus.o_valid;
         prev_r <= bus.o_ready;
         prev_d <= bus.o_data;
      end
   end

   // Index monitor: each op issues 0..WIDTH-1 then a single clear
   always @(negedge clk) begin
      if (!rst_n) begin
         idx_exp <= 0;
      end else begin
         if (mul_en) begin
            chk("mul_idx", longint'(mul_idx), idx_exp);
            idx_exp <= (idx_exp + 1) % WIDTH;
         end
         if (mul_clr) begin
            chk("clr_after_all_idx", idx_exp, 0);
            chk("clr_without_en", longint'(mul_en), 0);
            n_clr++;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) bus.o_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Call at posedge+1; returns at the posedge+1 after the accepting edge with i_valid low
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t e;
      int   n;
      bus.i_valid = 1'b1;
      bus.i_a     = a;
      bus.i_b     = b;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.i_ready) break;
         n++;
         if (n > 300) begin
            chk("accept_timeout", n, 0);
            break;
         end
      end
      if (n <= 300) begin
         e.a    = a;
         e.b    = b;
         e.prod = prod_of(a, b);
         e.cyc  = cyc;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals();
      chk("rst_i_ready", longint'(bus.i_ready), 1);
      chk("rst_o_valid", longint'(bus.o_valid), 0);
      chk("rst_o_data", longint'(bus.o_data), 0);
      chk("rst_o_busy", longint'(o_busy), 0);
      chk("rst_mul_en", longint'(mul_en), 0);
      chk("rst_mul_clr", longint'(mul_clr), 0);
      chk("rst_mul_idx", longint'(mul_idx), 0);
      chk("rst_mul_data0", longint'(mul_data0), 0);
      chk("rst_mul_data1", longint'(mul_data1), 0);
   endtask

   task automatic check_idle();
      @(negedge clk);
      chk("idle_busy", longint'(o_busy), 0);
      chk("idle_i_ready", longint'(bus.i_ready), 1);
      chk("idle_o_valid", longint'(bus.o_valid), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst_n       = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_a     = '0;
      bus.i_b     = '0;
      bus.o_ready = 1'b1;
      #3;
      check_reset_vals();
      #19 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed values, including the extremes
      send(8'd3, 8'd5);
      drain(100);
      check_idle();
      send(8'h80, 8'h80);
      send(8'h80, 8'h7f);
      send(8'hff, 8'h7f);
      send(8'h00, 8'hf9);
      drain(200);

      // Back-to-back stream of random pairs
      for (int i = 0; i < 4; i++) send(WIDTH'($urandom), WIDTH'($urandom));
      drain(200);

      // Stall in DONE with the next pair waiting
      bus.o_ready = 1'b0;
      send(8'd12, 8'hf7);
      fork
         send(8'd7, 8'hfd);
         begin
            n = 0;
            while (!bus.o_valid && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            chk("stall_reach_done", longint'(bus.o_valid), 1);
            repeat (4) @(posedge clk);
            #1;
            bus.o_ready = 1'b1;
         end
      join
      drain(100);

      // Reset in the middle of RUN (cnt=4), then a clean op
      send(8'h5b, 8'hc3);
      repeat (4) @(posedge clk);
      #1;
      chk("pre_abort_idx", longint'(mul_idx), 5);
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      sb.delete();
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'd2, 8'd3);
      drain(100);

      // Random pairs with random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         logic [WIDTH-1:0] a, b;
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         if ($urandom_range(0, 5) == 0) a = 8'h80;
         if ($urandom_range(0, 5) == 0) b = 8'h80;
         send(a, b);
      end
      drain(2000);
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      bus.o_ready = 1'b1;
      drain(100);
      check_idle();
      chk("clr_per_result", n_clr, n_results);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
